// File: rtl/cache_control.sv
// Control FSM for the two-way set-associative cache: hit handling, dirty-victim writeback, line allocate.
// Optional macro CACHE_CTRL_PERF_EN adds saturating hit/miss counters on hit_count/miss_count.
module cache_control (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        mem_resp,
    input  logic        hit0,
    input  logic        hit1,
    input  logic        lru,
    input  logic        dirty0,
    input  logic        dirty1,
    output logic        pmem_read,
    output logic        pmem_write,
    input  logic        pmem_resp,
    output logic        data_write0,
    output logic        data_write1,
    output logic        tag_write0,
    output logic        tag_write1,
    output logic        valid_write0,
    output logic        valid_write1,
    output logic        dirty_write0,
    output logic        dirty_write1,
    output logic        dirty_in,
    output logic        lru_write,
    output logic        lru_in,
    output logic        datain_sel,
    output logic        pmem_addr_sel
`ifdef CACHE_CTRL_PERF_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    typedef enum logic [1:0] {
        CHECK     = 2'b00,
        WRITEBACK = 2'b01,
        ALLOCATE  = 2'b10
    } state_e;

    state_e state_q, state_d;
    logic   way_q, way_d;
    logic   gap_q, gap_d;
    logic   pmem_read_q, pmem_read_d;
    logic   pmem_write_q, pmem_write_d;
    logic   req_s;
    logic   hit_s;
    logic   hit_way_s;

    // Requests are masked while reset is held so every output reads 0 in reset.
    assign req_s     = (mem_read | mem_write) & reset_n;
    assign hit_s     = hit0 | hit1;
    assign hit_way_s = hit1;

    assign pmem_read  = pmem_read_q;
    assign pmem_write = pmem_write_q;

    // State, captured victim way and registered pmem request lines.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= CHECK;
            way_q        <= 1'b0;
            gap_q        <= 1'b0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            way_q        <= way_d;
            gap_q        <= gap_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
        end
    end

    // Next-state decode plus Mealy array strobes and completion pulse.
    always_comb begin
        state_d       = state_q;
        way_d         = way_q;
        gap_d         = gap_q;
        mem_resp      = 1'b0;
        data_write0   = 1'b0;
        data_write1   = 1'b0;
        tag_write0    = 1'b0;
        tag_write1    = 1'b0;
        valid_write0  = 1'b0;
        valid_write1  = 1'b0;
        dirty_write0  = 1'b0;
        dirty_write1  = 1'b0;
        dirty_in      = 1'b0;
        lru_write     = 1'b0;
        lru_in        = 1'b0;
        datain_sel    = 1'b0;
        pmem_addr_sel = 1'b0;
        case (state_q)
            CHECK: begin
                if (req_s) begin
                    if (hit_s) begin
                        mem_resp  = 1'b1;
                        lru_write = 1'b1;
                        lru_in    = ~hit_way_s;
                        if (mem_write) begin
                            data_write0  = ~hit_way_s;
                            data_write1  = hit_way_s;
                            dirty_write0 = ~hit_way_s;
                            dirty_write1 = hit_way_s;
                            dirty_in     = 1'b1;
                        end else begin
                            dirty_in     = 1'b0;
                        end
                    end else begin
                        way_d   = lru;
                        gap_d   = 1'b0;
                        state_d = (lru ? dirty1 : dirty0) ? WRITEBACK : ALLOCATE;
                    end
                end else begin
                    state_d = CHECK;
                end
            end
            WRITEBACK: begin
                pmem_addr_sel = 1'b1;
                // One idle cycle follows the writeback so pmem sees its request drop before the fill read.
                if (pmem_resp) begin
                    state_d = ALLOCATE;
                    gap_d   = 1'b1;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            ALLOCATE: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (pmem_resp) begin
                    data_write0  = ~way_q;
                    data_write1  = way_q;
                    tag_write0   = ~way_q;
                    tag_write1   = way_q;
                    valid_write0 = ~way_q;
                    valid_write1 = way_q;
                    dirty_write0 = ~way_q;
                    dirty_write1 = way_q;
                    dirty_in     = 1'b0;
                    datain_sel   = 1'b1;
                    state_d      = CHECK;
                end else begin
                    state_d = ALLOCATE;
                end
            end
            default: begin
                state_d = CHECK;
                gap_d   = 1'b0;
            end
        endcase
        pmem_read_d  = (state_d == ALLOCATE) && !gap_d;
        pmem_write_d = (state_d == WRITEBACK);
    end

`ifdef CACHE_CTRL_PERF_EN
    logic [15:0] hit_count_q;
    logic [15:0] miss_count_q;
    logic        miss_s;

    assign miss_s     = (state_q == CHECK) && req_s && !hit_s;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    // Saturating event counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count_q  <= 16'h0000;
            miss_count_q <= 16'h0000;
        end else begin
            if (mem_resp && (hit_count_q != 16'hFFFF)) begin
                hit_count_q <= hit_count_q + 16'h0001;
            end else begin
                hit_count_q <= hit_count_q;
            end
            if (miss_s && (miss_count_q != 16'hFFFF)) begin
                miss_count_q <= miss_count_q + 16'h0001;
            end else begin
                miss_count_q <= miss_count_q;
            end
        end
    end
`endif

endmodule
